// File: rtl/demux4way16_stream_if.sv
// Bundled port interface for demux4way16_stream.
//
// Handshake rule, used by every channel of this bus: a word moves across a
// valid/ready pair exactly on a rising clk edge where both valid and ready are
// 1. A producer holding valid=1 keeps its data stable until that edge; ready
// may be observed without any obligation from the other side.
//
// Signals:
//   in[WIDTH], select[2], in_valid  : producer -> demux (select 0=A,1=B,2=C,3=D)
//   in_ready                        : demux -> producer (selected channel not full)
//   outA..D[WIDTH], validA..D       : demux -> consumers (head word of each FIFO)
//   readyA..D                       : consumers -> demux (pop head word)
//   countA..D[8]                    : delivered-word counters, only with DEMUX4_STATS_EN
//
// Modports: master = the producer/consumer environment, slave = the demux.
// Optional feature macro: DEMUX4_STATS_EN.
interface demux4way16_stream_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic [1:0]       select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] outA, outB, outC, outD;
  logic             validA, validB, validC, validD;
  logic             readyA, readyB, readyC, readyD;
`ifdef DEMUX4_STATS_EN
  logic [7:0]       countA, countB, countC, countD;

  modport master (
    output in, select, in_valid, readyA, readyB, readyC, readyD,
    input  in_ready, outA, outB, outC, outD, validA, validB, validC, validD,
           countA, countB, countC, countD
  );

  modport slave (
    input  in, select, in_valid, readyA, readyB, readyC, readyD,
    output in_ready, outA, outB, outC, outD, validA, validB, validC, validD,
           countA, countB, countC, countD
  );
`else
  modport master (
    output in, select, in_valid, readyA, readyB, readyC, readyD,
    input  in_ready, outA, outB, outC, outD, validA, validB, validC, validD
  );

  modport slave (
    input  in, select, in_valid, readyA, readyB, readyC, readyD,
    output in_ready, outA, outB, outC, outD, validA, validB, validC, validD
  );
`endif
endinterface

// File: rtl/demux4way16_stream.sv
// 1-to-4 stream demultiplexer with an independent 2-entry FIFO per channel.
//
// Ports:
//   clk      : single clock, all state updates on the rising edge
//   reset_n  : synchronous active-low reset (clears pointers, occupancies, counters)
//   bus      : demux4way16_stream_if.slave (input stream, four output streams)
//
// A word offered on in/select with in_valid=1 is pushed into the FIFO named by
// select when that FIFO holds fewer than 2 words. Each output shows its FIFO
// head (0 when empty) and pops on validX & readyX. in_ready depends only on
// select and the selected occupancy, never on any consumer ready, so there is
// no combinational path from consumers back to the producer.
//
// Optional feature macro: DEMUX4_STATS_EN adds 8-bit wrapping per-channel pop
// counters countA..D.
module demux4way16_stream #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  demux4way16_stream_if.slave     bus
);

  logic [WIDTH-1:0] mem  [4][2];
  logic [3:0]       wp;
  logic [3:0]       rp;
  logic [1:0]       occ  [4];

  logic [3:0]       rdy;
  logic [3:0]       vld;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [WIDTH-1:0] head [4];

  assign rdy = {bus.readyD, bus.readyC, bus.readyB, bus.readyA};

  assign bus.in_ready = (occ[bus.select] != 2'd2);

  always_comb begin
    vld  = '0;
    push = '0;
    pop  = '0;
    for (int c = 0; c < 4; c++) begin
      head[c] = '0;
    end
    for (int c = 0; c < 4; c++) begin
      vld[c]  = (occ[c] != 2'd0);
      push[c] = bus.in_valid && bus.in_ready && (bus.select == 2'(c));
      // Ready on an empty channel is ignored, so no underflow is possible.
      pop[c]  = vld[c] && rdy[c];
      // Empty channels drive 0 regardless of stale storage contents.
      head[c] = vld[c] ? mem[c][rp[c]] : '0;
    end
  end

  // Pointer/occupancy state. Push and pop on the same channel in one cycle
  // cancel in occupancy while both pointers advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      for (int c = 0; c < 4; c++) begin
        occ[c] <= 2'd0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (push[c]) wp[c] <= ~wp[c];
        if (pop[c])  rp[c] <= ~rp[c];
        occ[c] <= occ[c] + {1'b0, push[c]} - {1'b0, pop[c]};
      end
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (reset_n && push[c]) mem[c][wp[c]] <= bus.in;
    end
  end

  assign bus.outA   = head[0];
  assign bus.outB   = head[1];
  assign bus.outC   = head[2];
  assign bus.outD   = head[3];
  assign bus.validA = vld[0];
  assign bus.validB = vld[1];
  assign bus.validC = vld[2];
  assign bus.validD = vld[3];

`ifdef DEMUX4_STATS_EN
  logic [7:0] cnt [4];

  // Counts delivered words; wraps 255 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < 4; c++) begin
        cnt[c] <= 8'd0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (pop[c]) cnt[c] <= cnt[c] + 8'd1;
      end
    end
  end

  assign bus.countA = cnt[0];
  assign bus.countB = cnt[1];
  assign bus.countC = cnt[2];
  assign bus.countD = cnt[3];
`endif

endmodule

// File: tb/tb_demux4way16_stream.sv
// Self-checking bench for demux4way16_stream: directed vectors with
// hand-computed expectations plus a queue-based reference model compared
// against the DUT on every falling clock edge after the first reset.
module tb_demux4way16_stream;

  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [WIDTH-1:0] din;
  logic [1:0]       sel;
  logic             vin;
  logic [3:0]       rdyv;

  demux4way16_stream_if #(.WIDTH(WIDTH)) bus ();

  assign bus.in       = din;
  assign bus.select   = sel;
  assign bus.in_valid = vin;
  assign bus.readyA   = rdyv[0];
  assign bus.readyB   = rdyv[1];
  assign bus.readyC   = rdyv[2];
  assign bus.readyD   = rdyv[3];

  demux4way16_stream #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  logic [WIDTH-1:0] dout [4];
  logic [3:0]       dval;
  assign dout[0] = bus.outA;
  assign dout[1] = bus.outB;
  assign dout[2] = bus.outC;
  assign dout[3] = bus.outD;
  assign dval    = {bus.validD, bus.validC, bus.validB, bus.validA};

`ifdef DEMUX4_STATS_EN
  logic [7:0] dcnt [4];
  assign dcnt[0] = bus.countA;
  assign dcnt[1] = bus.countB;
  assign dcnt[2] = bus.countC;
  assign dcnt[3] = bus.countD;
`endif

  // ---------------- scoreboard / report counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is a plain queue of at most two words; counters are
  // unbounded ints reduced modulo 256 at comparison time.
  logic [WIDTH-1:0] exp_q [4][$];
  int               mcnt  [4];
  bit               started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        exp_q[c].delete();
        mcnt[c] = 0;
      end
      started = 1'b1;
    end else begin
      for (int c = 0; c < 4; c++) begin
        int sz;
        sz = exp_q[c].size();
        if (sz > 0 && rdyv[c]) begin
          void'(exp_q[c].pop_front());
          mcnt[c]++;
        end
        if (vin && (int'(sel) == c) && sz < 2) exp_q[c].push_back(din);
      end
    end
  end

  // One compare process: every falling edge once the first reset has been seen.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_q[sel].size() < 2});
      for (int c = 0; c < 4; c++) begin
        check($sformatf("valid[%0d]", c), {31'd0, dval[c]}, {31'd0, exp_q[c].size() != 0});
        check($sformatf("out[%0d]", c), {16'd0, dout[c]},
              {16'd0, (exp_q[c].size() != 0) ? exp_q[c][0] : 16'h0000});
`ifdef DEMUX4_STATS_EN
        check($sformatf("count[%0d]", c), {24'd0, dcnt[c]}, 32'(mcnt[c] % 256));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [WIDTH-1:0] d);
    sel = s;
    din = d;
    vin = 1'b1;
    tick();
    vin = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    din   = '0;
    sel   = 2'd0;
    vin   = 1'b0;
    rdyv  = 4'b0000;

    // Reset then idle.
    do_reset();
    check("rst_validA", {31'd0, bus.validA}, 32'd0);
    check("rst_validD", {31'd0, bus.validD}, 32'd0);
    check("rst_outB", {16'd0, bus.outB}, 32'h0000);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef DEMUX4_STATS_EN
    check("rst_countC", {24'd0, bus.countC}, 32'd0);
`endif

    // Single push to C, then fill C and check select-dependent in_ready.
    push(2'd2, 16'h1234);
    check("c1_validC", {31'd0, bus.validC}, 32'd1);
    check("c1_outC", {16'd0, bus.outC}, 32'h1234);
    check("c1_validABD", {29'd0, bus.validA, bus.validB, bus.validD}, 32'd0);
    push(2'd2, 16'h5678);
    sel = 2'd2;
    #1;
    check("c2_in_ready_sel2", {31'd0, bus.in_ready}, 32'd0);
    sel = 2'd0;
    #1;
    check("c2_in_ready_sel0", {31'd0, bus.in_ready}, 32'd1);
    // Offered word to full C must be stalled and dropped from consideration.
    sel = 2'd2; din = 16'hDEAD; vin = 1'b1;
    tick();
    vin = 1'b0;
    check("c2_outC_kept", {16'd0, bus.outC}, 32'h1234);
    rdyv = 4'b0100;
    tick();
    check("c_drain_outC", {16'd0, bus.outC}, 32'h5678);
    tick();
    rdyv = 4'b0000;
    check("c_drain_validC", {31'd0, bus.validC}, 32'd0);

    // B full, then drained on two consecutive cycles.
    push(2'd1, 16'hAAAA);
    push(2'd1, 16'hBBBB);
    check("b_full_outB", {16'd0, bus.outB}, 32'hAAAA);
    rdyv = 4'b0010;
    tick();
    check("b_pop1_outB", {16'd0, bus.outB}, 32'hBBBB);
    tick();
    rdyv = 4'b0000;
    check("b_pop2_validB", {31'd0, bus.validB}, 32'd0);
    check("b_pop2_outB", {16'd0, bus.outB}, 32'h0000);
`ifdef DEMUX4_STATS_EN
    check("b_countB", {24'd0, bus.countB}, 32'd2);
`endif

    // D at occupancy 1 with simultaneous push and pop.
    push(2'd3, 16'h0001);
    rdyv = 4'b1000;
    push(2'd3, 16'h0002);
    check("d_sim_validD", {31'd0, bus.validD}, 32'd1);
    check("d_sim_outD", {16'd0, bus.outD}, 32'h0002);
    tick();
    rdyv = 4'b0000;
    check("d_occ1_validD", {31'd0, bus.validD}, 32'd0);

    // Ready on an empty channel is ignored.
    rdyv = 4'b0001;
    tick();
    tick();
    rdyv = 4'b0000;
    push(2'd0, 16'h4242);
    check("a_after_idle_ready", {16'd0, bus.outA}, 32'h4242);
    rdyv = 4'b0001;
    tick();
    rdyv = 4'b0000;

    // A full, reset with concurrent push/pop attempts.
    push(2'd0, 16'h1111);
    push(2'd0, 16'h2222);
    sel = 2'd0;
    #1;
    check("a_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    sel = 2'd1; din = 16'h7777; vin = 1'b1; rdyv = 4'b0001;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; vin = 1'b0; rdyv = 4'b0000; sel = 2'd0;
    #1;
    check("a_rst_validA", {31'd0, bus.validA}, 32'd0);
    check("a_rst_outA", {16'd0, bus.outA}, 32'h0000);
    check("a_rst_validB", {31'd0, bus.validB}, 32'd0);
    check("a_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef DEMUX4_STATS_EN
    check("a_rst_countA", {24'd0, bus.countA}, 32'd0);
`endif

    // 257 deliveries on A: counter wraps to 1.
    for (int i = 0; i < 257; i++) begin
      push(2'd0, 16'(i * 3 + 5));
      rdyv = 4'b0001;
      tick();
      rdyv = 4'b0000;
    end
    check("wrap_validA", {31'd0, bus.validA}, 32'd0);
`ifdef DEMUX4_STATS_EN
    check("wrap_countA", {24'd0, bus.countA}, 32'd1);
`endif

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
